// File: rtl/ravan_decrypt_stream_if.sv
// ravan_decrypt_stream_if
//   Ciphertext and plaintext valid/ready streams of the RAVAN decryption
//   engine, bundled so that a single port carries both directions.
//
//   Signals
//     in_valid   ciphertext word valid        (master -> engine)
//     in_data    64-bit ciphertext word       (master -> engine)
//     in_ready   engine can accept a word     (engine -> master)
//     out_valid  plaintext word valid         (engine -> master)
//     out_data   64-bit plaintext word        (engine -> master)
//     out_ready  downstream accepts plaintext (master -> engine)
//
//   Modports
//     slave   the decryption engine
//     master  the producer/consumer that surrounds the engine
interface ravan_decrypt_stream_if;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/ravan_decrypt_stream.sv
// ravan_decrypt_stream
//   Iterative RAVAN decryption engine. Each accepted 64-bit ciphertext word is
//   run through ROUNDS inverse rounds, x = rotr(x, r+1) ^ K[r] for
//   r = ROUNDS-1 down to 0, with K[r] = key[64r+63:64r], one round per clock.
//   The plaintext is then presented on the output stream until taken.
//
//   Parameters
//     ROUNDS      number of inverse rounds, 1..8
//
//   Ports
//     clk         clock, rising edge
//     rst         asynchronous reset, active low
//     i_key_load  latch i_key into the key register (honoured only when idle)
//     i_key       512-bit hashed key
//     o_busy      high whenever the engine is not idle
//     s_if        ciphertext in / plaintext out streams (slave side)
module ravan_decrypt_stream #(
    parameter int ROUNDS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_key_load,
    input  logic [511:0]            i_key,
    output logic                    o_busy,
    ravan_decrypt_stream_if.slave   s_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic [511:0] r_key;
    logic [2:0]   r_round;
    logic [63:0]  r_data;
    logic [63:0]  r_out_data;

    logic [63:0]  w_slice [0:7];
    logic [3:0]   w_amt;
    logic [63:0]  w_rot;
    logic [63:0]  w_round_result;
    logic         w_accept;
    logic         w_last;

    // Carve the key register into its eight 64-bit round keys.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slice
            assign w_slice[gi] = r_key[64*gi +: 64];
        end
    endgenerate

    // Rotate amount is r+1 (1..8), so both shifts stay inside the word.
    assign w_amt          = {1'b0, r_round} + 4'd1;
    assign w_rot          = (r_data >> w_amt) | (r_data << (7'd64 - {3'b000, w_amt}));
    assign w_round_result = w_rot ^ w_slice[r_round];

    assign w_accept = (r_state == IDLE) && s_if.in_valid;
    assign w_last   = (r_state == ROUND) && (r_round == 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        s_if.in_ready  = 1'b0;
        s_if.out_valid = 1'b0;
        o_busy         = 1'b1;
        case (r_state)
            IDLE: begin
                s_if.in_ready = 1'b1;
                o_busy        = 1'b0;
                if (s_if.in_valid) begin
                    w_state_next = ROUND;
                end
            end
            ROUND: begin
                if (r_round == 3'd0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                s_if.out_valid = 1'b1;
                if (s_if.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The key can only change while idle, so a word always finishes with the
    // key it started with. A load on the accepting edge is already visible to
    // the first round because rounds begin on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key <= '0;
        end else if ((r_state == IDLE) && i_key_load) begin
            r_key <= i_key;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_round <= '0;
        end else if (w_accept) begin
            r_data  <= s_if.in_data;
            r_round <= LAST_ROUND;
        end else if (r_state == ROUND) begin
            r_data <= w_round_result;
            if (r_round != 3'd0) begin
                r_round <= r_round - 3'd1;
            end
        end
    end

    // Separate result register: the working register churns during the next
    // word's rounds, but the output must keep the previous plaintext.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data <= '0;
        end else if (w_last) begin
            r_out_data <= w_round_result;
        end
    end

    assign s_if.out_data = r_out_data;

endmodule

// File: tb/tb_ravan_decrypt_stream.sv
module tb_ravan_decrypt_stream;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [511:0] key;

    logic [2:0]   tb_iv;
    logic [63:0]  tb_id [3];
    logic [2:0]   tb_or;
    logic [2:0]   ov;
    logic [2:0]   ir;
    logic [2:0]   bz;
    logic [63:0]  od [3];

    int n_total;
    int n_pass;

    ravan_decrypt_stream_if if8 ();
    ravan_decrypt_stream_if if5 ();
    ravan_decrypt_stream_if if1 ();

    assign if8.in_valid  = tb_iv[0];
    assign if8.in_data   = tb_id[0];
    assign if8.out_ready = tb_or[0];
    assign if5.in_valid  = tb_iv[1];
    assign if5.in_data   = tb_id[1];
    assign if5.out_ready = tb_or[1];
    assign if1.in_valid  = tb_iv[2];
    assign if1.in_data   = tb_id[2];
    assign if1.out_ready = tb_or[2];

    assign ov = {if1.out_valid, if5.out_valid, if8.out_valid};
    assign ir = {if1.in_ready, if5.in_ready, if8.in_ready};
    assign od[0] = if8.out_data;
    assign od[1] = if5.out_data;
    assign od[2] = if1.out_data;

    ravan_decrypt_stream #(.ROUNDS(8)) u_dut8 (
        .clk(clk), .rst(rst), .i_key_load(key_load), .i_key(key), .o_busy(bz[0]), .s_if(if8.slave)
    );
    ravan_decrypt_stream #(.ROUNDS(5)) u_dut5 (
        .clk(clk), .rst(rst), .i_key_load(key_load), .i_key(key), .o_busy(bz[1]), .s_if(if5.slave)
    );
    ravan_decrypt_stream #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_key_load(key_load), .i_key(key), .o_busy(bz[2]), .s_if(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           sel;
        logic [511:0] k;
        logic [63:0]  din;
        logic [63:0]  exp;
    } vec_t;

    function automatic int rounds_of(input int s);
        case (s)
            0: return 8;
            1: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // Transmit-side reference cipher.
    function automatic logic [63:0] fwd(input logic [63:0] p, input logic [511:0] k, input int nr);
        logic [63:0] x;
        x = p;
        for (int r = 0; r < nr; r++) begin
            x = rotl(x ^ k[64*r +: 64], r + 1);
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One word through instance sel; inputs change 1 time unit after an edge.
    task automatic run_word(input int sel, input logic [63:0] din, input logic ld,
                            input logic [511:0] k, output logic [63:0] res, output int lat);
        key      = k;
        key_load = ld;
        tb_id[sel] = din;
        tb_iv[sel] = 1'b1;
        @(posedge clk);
        #1;
        key_load   = 1'b0;
        tb_iv[sel] = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = od[sel];
        tb_or[sel] = 1'b1;
        @(posedge clk);
        #1;
        tb_or[sel] = 1'b0;
    endtask

    vec_t         vecs [8];
    logic [63:0]  res;
    logic [63:0]  held;
    int           lat;
    logic [511:0] kz;
    logic [511:0] kb;

    initial begin
        n_total  = 0;
        n_pass   = 0;
        kz       = '0;
        kb       = '0;
        kb[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;

        vecs[0] = '{0, kz, 64'h0000_0000_0000_0001, 64'h0000_0000_1000_0000};
        vecs[1] = '{0, kb, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{0, {64'h1, 448'h0}, 64'h0, 64'h0000_0010_0000_0000};
        vecs[3] = '{0, kz, 64'h8000_0000_0000_0000, 64'h0000_0000_0800_0000};
        vecs[4] = '{0, kz, 64'h0000_0000_0000_000F, 64'h0000_0000_F000_0000};
        vecs[5] = '{0, kz, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{1, kz, 64'h0000_0000_0000_0001, 64'h0002_0000_0000_0000};
        vecs[7] = '{2, kz, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};

        rst      = 1'b0;
        key_load = 1'b0;
        key      = '0;
        tb_iv    = '0;
        tb_or    = '0;
        for (int s = 0; s < 3; s++) tb_id[s] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_out_valid[%0d]", s), 64'(ov[s]), 64'd0);
            check($sformatf("reset_out_data[%0d]", s), od[s], 64'd0);
            check($sformatf("reset_busy[%0d]", s), 64'(bz[s]), 64'd0);
            check($sformatf("reset_in_ready[%0d]", s), 64'(ir[s]), 64'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors; key loaded on the same edge the word is accepted.
        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].sel, vecs[i].din, 1'b1, vecs[i].k, res, lat);
            $display("vec %0d rounds=%0d in=%h out=%h lat=%0d", i, rounds_of(vecs[i].sel), vecs[i].din, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(rounds_of(vecs[i].sel)));
            check($sformatf("vec%0d_idle", i), 64'(bz[vecs[i].sel]), 64'd0);
        end

        // Round trip through the forward model for every round count.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [511:0] k;
                logic [63:0]  pt;
                logic [63:0]  ct;
                for (int w = 0; w < 16; w++) k[32*w +: 32] = $urandom;
                pt = {$urandom, $urandom};
                ct = fwd(pt, k, rounds_of(s));
                run_word(s, ct, 1'b1, k, res, lat);
                $display("rt rounds=%0d ct=%h pt=%h out=%h", rounds_of(s), ct, pt, res);
                check("round_trip", res, pt);
            end
        end

        // Backpressure: result held for 5 cycles, transferred on first ready.
        key = kz; key_load = 1'b1;
        tb_id[0] = 64'h1; tb_iv[0] = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0; tb_iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd8);
        held = od[0];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            $display("bp cycle %0d valid=%0b data=%h in_ready=%0b busy=%0b", c, ov[0], od[0], ir[0], bz[0]);
            check("bp_valid", 64'(ov[0]), 64'd1);
            check("bp_data", od[0], 64'h0000_0000_1000_0000);
            check("bp_in_ready", 64'(ir[0]), 64'd0);
            check("bp_busy", 64'(bz[0]), 64'd1);
        end
        check("bp_held", od[0], held);
        tb_or[0] = 1'b1;
        @(posedge clk);
        #1;
        tb_or[0] = 1'b0;
        check("bp_after_valid", 64'(ov[0]), 64'd0);
        check("bp_after_in_ready", 64'(ir[0]), 64'd1);
        check("bp_after_busy", 64'(bz[0]), 64'd0);
        check("bp_data_kept", od[0], 64'h0000_0000_1000_0000);

        // key_load during ROUND is ignored for this and the following word.
        key = kz; key_load = 1'b1;
        tb_id[0] = 64'h1; tb_iv[0] = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0; tb_iv[0] = 1'b0;
        @(posedge clk);
        #1;
        key = kb; key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        lat = 2;
        while (!ov[0] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = od[0];
        tb_or[0] = 1'b1;
        @(posedge clk);
        #1;
        tb_or[0] = 1'b0;
        $display("ignored key_load word1 out=%h", res);
        check("ign_key_word1", res, 64'h0000_0000_1000_0000);
        run_word(0, 64'h1, 1'b0, kb, res, lat);
        $display("ignored key_load word2 out=%h", res);
        check("ign_key_word2", res, 64'h0000_0000_1000_0000);

        // Asynchronous reset in the 3rd ROUND cycle clears the key register.
        key = kb; key_load = 1'b1;
        tb_id[0] = 64'h1; tb_iv[0] = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0; tb_iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_busy", 64'(bz[0]), 64'd1);
        rst = 1'b0;
        #1;
        $display("reset mid-round valid=%0b busy=%0b in_ready=%0b", ov[0], bz[0], ir[0]);
        check("mid_reset_valid", 64'(ov[0]), 64'd0);
        check("mid_reset_busy", 64'(bz[0]), 64'd0);
        check("mid_reset_in_ready", 64'(ir[0]), 64'd1);
        check("mid_reset_out_data", od[0], 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_word(0, 64'h1, 1'b0, kb, res, lat);
        $display("post-reset word out=%h lat=%0d", res, lat);
        check("post_reset_data", res, 64'h0000_0000_1000_0000);
        check("post_reset_latency", 64'(lat), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ravan_decrypt_stream.md
Name: ravan_decrypt_stream

Overview:
- Stand-alone, handshaked RAVAN decryption engine for the receive end of a link.
- Accepts 64-bit ciphertext words over a valid/ready stream and decrypts each one with an iterative inverse-round datapath keyed by a locally held 512-bit hashed key.
- Returns plaintext over a second valid/ready stream.
- Inverts the RAVAN round function used on the transmit side, so a word encrypted there with the same key and round count comes back bit-exact.

Parameters:
- ROUNDS, 8: number of inverse rounds, legal range 1..8. Round r uses key slice K[r] = key[64r+63:64r].

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- key_load  input  1  latch key into the internal key register. Accepted only in IDLE.
- key  input  512  hashed key, already processed by the SHA pipeline.
- in_valid  input  1  ciphertext word valid.
- in_data  input  64  ciphertext word.
- in_ready  output  1  engine can accept a word. High only in IDLE.
- out_valid  output  1  plaintext word valid.
- out_data  output  64  plaintext word.
- out_ready  input  1  downstream accepts plaintext.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, key register=0, round counter=0, data register=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1, since it is decoded from IDLE.
  - Outputs hold these values for as long as rst is low.
- Forward cipher (defined here as the model reference): for r=0..ROUNDS-1, x = rotl(x ^ K[r], r+1).
- Inverse, implemented by this block: for r=ROUNDS-1 down to 0, x = rotr(x, r+1) ^ K[r]. All arithmetic is 64-bit; rotates wrap with no bit loss.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with key_load=1, the key register takes key.
  - On an edge with in_valid=1: x<=in_data, r<=ROUNDS-1, go to ROUND.
  - key_load and in_valid may be high on the same edge: both take effect, and the rounds use the new key.
- ROUND:
  - Each edge: x <= rotr(x, r+1) ^ K[r].
  - If r==0, go to DONE; else r<=r-1.
  - Exactly ROUNDS edges are spent in ROUND.
- DONE:
  - out_valid=1, out_data=x, held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
- Latency:
  - out_valid rises ROUNDS edges after the accepting edge.
  - Throughput is one word per ROUNDS+2 cycles when out_ready=1.
- In ROUND and DONE: key_load is ignored (key register unchanged) and in_valid is ignored (in_ready=0).
- out_data keeps the last result after the transfer until the next DONE. Only out_valid qualifies it.
- Reset mid-operation (any state): the word in flight is discarded, and the FSM and outputs return to reset values immediately.
- ROUNDS=1: a single inverse round using K[0] with a 1-bit rotate. out_valid rises 1 edge after acceptance.

Test Plan:
- Key register loaded with all zeros, ROUNDS=8, in_data=64'h0000_0000_0000_0001 -> out_data=64'h0000_0000_1000_0000 (net rotr 36); out_valid rises 8 edges after the accepting edge.
- key_load with K[0]=64'hFFFF_FFFF_FFFF_FFFF and K[1..7]=0, in_data=0 -> out_data=64'hFFFF_FFFF_FFFF_FFFF.
- Round trip: 1000 random keys and plaintexts, ciphertext generated by the forward model, then decrypted -> out_data equals the plaintext every time. Repeat with ROUNDS=1 and ROUNDS=5.
- Backpressure: out_ready held low 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0, busy=1. The word is transferred on the first cycle out_ready=1, and the FSM returns to IDLE on the next cycle.
- Ignored key_load: key_load with a new key during ROUND -> the current word decrypts with the old key, and the next word also uses the old key.
- Reset: rst pulled low on the 3rd ROUND cycle -> out_valid=0 and busy=0 asynchronously. After release, the key register reads as 0 (an all-zero-key decrypt of 64'h1 gives 64'h0000_0000_1000_0000), and a new word is accepted normally.
